// File: rtl/clks_alot_generator.sv
// rtl/clks_alot_generator.sv - programmable IO clock synthesiser with glitch-free pause and stop
module clks_alot_generator #(
  parameter int RATE_COUNTER_WIDTH = 32,
  parameter int PAUSE_WIDTH        = 32
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          enable_i,
  input  logic                          pause_req_i,
  input  logic                          diff_en_i,
  input  logic                          even_50_50_en_i,
  input  logic [RATE_COUNTER_WIDTH-1:0] high_rate_m1_i,
  input  logic [RATE_COUNTER_WIDTH-1:0] low_rate_m1_i,
  output logic                          clk_o,
  output logic [1:0]                    pins_o,
  output logic [3:0]                    events_o,
  output logic                          pause_active_o,
  output logic [PAUSE_WIDTH-1:0]        pause_duration_o,
  output logic                          locked_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    PAUSED = 2'd3
  } state_t;

  localparam logic [RATE_COUNTER_WIDTH-1:0] CNT_ONE = RATE_COUNTER_WIDTH'(1);
  localparam logic [PAUSE_WIDTH-1:0]        DUR_ONE = PAUSE_WIDTH'(1);

  state_t                        state_q, state_d;
  logic [RATE_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [RATE_COUNTER_WIDTH-1:0] lat_high_q, lat_high_d;
  logic [RATE_COUNTER_WIDTH-1:0] lat_low_q, lat_low_d;
  logic [RATE_COUNTER_WIDTH-1:0] req_high, req_low;
  logic                          phantom_low_q, phantom_low_d;
  logic [1:0]                    stable_q, stable_d;
  logic                          relatch, rates_same;
  logic                          clk_d, neg_d, locked_d;
  logic [3:0]                    events_d;
  logic [PAUSE_WIDTH-1:0]        dur_d;

  // Rates that would be latched if a new period started this cycle
  assign req_high   = high_rate_m1_i;
  assign req_low    = even_50_50_en_i ? high_rate_m1_i : low_rate_m1_i;
  assign rates_same = (req_high == lat_high_q) && (req_low == lat_low_q);

  // Next state, phase/phantom counters, lock tracking and next registered outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lat_high_d    = lat_high_q;
    lat_low_d     = lat_low_q;
    phantom_low_d = phantom_low_q;
    stable_d      = stable_q;
    locked_d      = locked_o;
    dur_d         = pause_duration_o;
    relatch       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          if (pause_req_i) begin
            state_d = PAUSED;
          end else begin
            state_d  = HIGH;
            relatch  = 1'b1;
            stable_d = 2'd0;
          end
        end
      end
      HIGH: begin
        if (cnt_q == lat_high_q) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LOW: begin
        if (cnt_q == lat_low_q) begin
          if (!enable_i) begin
            state_d = IDLE;
          end else if (pause_req_i) begin
            state_d = PAUSED;
          end else begin
            state_d = HIGH;
            relatch = 1'b1;
            // A period just completed: count it towards lock unless the rates move
            if (!rates_same) begin
              stable_d = 2'd0;
              locked_d = 1'b0;
            end else begin
              if (stable_q != 2'd2) stable_d = stable_q + 2'd1;
              if (stable_q != 2'd0) locked_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PAUSED: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (!pause_req_i) begin
          state_d  = HIGH;
          relatch  = 1'b1;
          stable_d = 2'd0;
        end else if (!phantom_low_q) begin
          if (cnt_q == lat_high_q) begin
            phantom_low_d = 1'b1;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          if (cnt_q == lat_low_q) begin
            phantom_low_d = 1'b0;
            cnt_d         = '0;
            if (pause_duration_o != '1) dur_d = pause_duration_o + DUR_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (relatch) begin
      lat_high_d = req_high;
      lat_low_d  = req_low;
      cnt_d      = '0;
    end

    // Leaving active generation drops lock and restarts the phase count
    if ((state_d != state_q) && ((state_d == IDLE) || (state_d == PAUSED))) begin
      locked_d = 1'b0;
      stable_d = 2'd0;
      cnt_d    = '0;
    end

    if ((state_d == PAUSED) && (state_q != PAUSED)) begin
      dur_d         = '0;
      phantom_low_d = 1'b0;
    end

    clk_d    = (state_d == HIGH);
    neg_d    = diff_en_i & ~clk_d;
    events_d = 4'b0000;
    if (state_d == HIGH) begin
      events_d = (cnt_d == '0) ? 4'b1000 : 4'b0100;
    end else if (state_d == LOW) begin
      events_d = (cnt_d == '0) ? 4'b0010 : 4'b0001;
    end
  end

  // State register and registered outputs, all updated on the same edge
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      lat_high_q       <= '0;
      lat_low_q        <= '0;
      phantom_low_q    <= 1'b0;
      stable_q         <= 2'd0;
      clk_o            <= 1'b0;
      pins_o           <= 2'b00;
      events_o         <= 4'b0000;
      pause_active_o   <= 1'b0;
      pause_duration_o <= '0;
      locked_o         <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      lat_high_q       <= lat_high_d;
      lat_low_q        <= lat_low_d;
      phantom_low_q    <= phantom_low_d;
      stable_q         <= stable_d;
      clk_o            <= clk_d;
      pins_o           <= {clk_d, neg_d};
      events_o         <= events_d;
      pause_active_o   <= (state_d == PAUSED);
      pause_duration_o <= dur_d;
      locked_o         <= locked_d;
    end
  end

endmodule

// File: tb/tb_clks_alot_generator.sv
// tb/tb_clks_alot_generator.sv - self-checking bench for clks_alot_generator
module tb_clks_alot_generator;

  localparam int RCW  = 8;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n;
  logic           enable_i;
  logic           pause_req_i;
  logic           diff_en_i;
  logic           even_50_50_en_i;
  logic [RCW-1:0] high_rate_m1_i;
  logic [RCW-1:0] low_rate_m1_i;
  logic           clk_o;
  logic [1:0]     pins_o;
  logic [3:0]     events_o;
  logic           pause_active_o;
  logic [PW-1:0]  pause_duration_o;
  logic           locked_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 sys_clk = ~sys_clk;

  clks_alot_generator #(
    .RATE_COUNTER_WIDTH(RCW),
    .PAUSE_WIDTH       (PW)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .enable_i        (enable_i),
    .pause_req_i     (pause_req_i),
    .diff_en_i       (diff_en_i),
    .even_50_50_en_i (even_50_50_en_i),
    .high_rate_m1_i  (high_rate_m1_i),
    .low_rate_m1_i   (low_rate_m1_i),
    .clk_o           (clk_o),
    .pins_o          (pins_o),
    .events_o        (events_o),
    .pause_active_o  (pause_active_o),
    .pause_duration_o(pause_duration_o),
    .locked_o        (locked_o)
  );

  // Reference model: phases described by remaining-cycle countdowns and lengths
  typedef enum {M_IDLE, M_HIGH, M_LOW, M_PAUSED} mphase_t;
  mphase_t m_phase;
  int      m_rem, m_len_high, m_len_low, m_ph_rem, m_dur;
  bit      m_first, m_ph_low, m_locked, m_diff;
  int      hist_h[$];
  int      hist_l[$];

  function automatic void m_reset();
    m_phase = M_IDLE; m_rem = 0; m_len_high = 1; m_len_low = 1;
    m_ph_rem = 0; m_dur = 0; m_first = 0; m_ph_low = 0;
    m_locked = 0; m_diff = 0;
    hist_h.delete(); hist_l.delete();
  endfunction

  function automatic void m_go_high(input int nh, input int nl);
    m_len_high = nh; m_len_low = nl;
    m_phase = M_HIGH; m_rem = nh; m_first = 1;
  endfunction

  function automatic void m_go_idle();
    m_phase = M_IDLE; m_locked = 0;
    hist_h.delete(); hist_l.delete();
  endfunction

  function automatic void m_go_pause();
    m_phase = M_PAUSED; m_locked = 0; m_dur = 0;
    m_ph_low = 0; m_ph_rem = m_len_high;
    hist_h.delete(); hist_l.delete();
  endfunction

  function automatic void m_step();
    int nh, nl;
    if (!sys_rst_n) begin
      m_reset();
      return;
    end
    m_diff = diff_en_i;
    nh = int'(high_rate_m1_i) + 1;
    nl = int'(even_50_50_en_i ? high_rate_m1_i : low_rate_m1_i) + 1;
    case (m_phase)
      M_IDLE: if (enable_i) begin
        if (pause_req_i) m_go_pause();
        else m_go_high(nh, nl);
      end
      M_HIGH: if (m_rem == 1) begin
        m_phase = M_LOW; m_rem = m_len_low; m_first = 1;
      end else begin
        m_rem--; m_first = 0;
      end
      M_LOW: if (m_rem == 1) begin
        if (!enable_i) m_go_idle();
        else if (pause_req_i) m_go_pause();
        else begin
          hist_h.push_back(m_len_high); hist_l.push_back(m_len_low);
          if (hist_h.size() > 2) begin
            void'(hist_h.pop_front()); void'(hist_l.pop_front());
          end
          m_locked = (hist_h.size() == 2) && (hist_h[0] == nh) && (hist_h[1] == nh)
                     && (hist_l[0] == nl) && (hist_l[1] == nl);
          m_go_high(nh, nl);
        end
      end else begin
        m_rem--; m_first = 0;
      end
      M_PAUSED: begin
        if (!enable_i) m_go_idle();
        else if (!pause_req_i) m_go_high(nh, nl);
        else if (m_ph_rem == 1) begin
          if (m_ph_low) begin
            if (m_dur < PMAX) m_dur++;
            m_ph_low = 0; m_ph_rem = m_len_high;
          end else begin
            m_ph_low = 1; m_ph_rem = m_len_low;
          end
        end else begin
          m_ph_rem--;
        end
      end
      default: m_go_idle();
    endcase
  endfunction

  function automatic logic [10:0] exp_vec();
    logic       c;
    logic [3:0] ev;
    c  = (m_phase == M_HIGH);
    ev = 4'b0000;
    if (m_phase == M_HIGH) ev = m_first ? 4'b1000 : 4'b0100;
    if (m_phase == M_LOW)  ev = m_first ? 4'b0010 : 4'b0001;
    return {c, c, m_diff & ~c, ev, (m_phase == M_PAUSED), PW'(m_dur), m_locked};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {clk_o, pins_o, events_o, pause_active_o, pause_duration_o, locked_o};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    m_step();
    #1;
    cyc++;
    check("model_outputs", longint'(dut_vec()), longint'(exp_vec()));
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0; enable_i = 1'b0; pause_req_i = 1'b0; diff_en_i = 1'b0;
    even_50_50_en_i = 1'b0; high_rate_m1_i = '0; low_rate_m1_i = '0;
    tick();
    check("reset_state", longint'(dut_vec()), 0);
    sys_rst_n = 1'b1;
  endtask

  bit rec_clk[$];
  bit rec_lock[$];

  function automatic int run_len(input int start, input bit v);
    int n = 0;
    while ((start + n) < rec_clk.size() && rec_clk[start + n] == v) n++;
    return n;
  endfunction

  typedef struct {
    int h_m1;
    int l_m1;
    bit even;
    bit diff;
    int exp_hi;
    int exp_lo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int per;
    vecs[0] = '{2,   4,   1'b0, 1'b0, 3,   5};
    vecs[1] = '{2,   9,   1'b1, 1'b0, 3,   3};
    vecs[2] = '{0,   0,   1'b0, 1'b1, 1,   1};
    vecs[3] = '{0,   7,   1'b0, 1'b1, 1,   8};
    vecs[4] = '{5,   0,   1'b0, 1'b0, 6,   1};
    vecs[5] = '{255, 255, 1'b0, 1'b0, 256, 256};

    m_reset();
    sys_rst_n = 1'b0; enable_i = 1'b0; pause_req_i = 1'b0; diff_en_i = 1'b0;
    even_50_50_en_i = 1'b0; high_rate_m1_i = '0; low_rate_m1_i = '0;

    // Rate table: phase lengths, first rising edge and lock timing
    foreach (vecs[i]) begin
      do_reset();
      high_rate_m1_i = RCW'(vecs[i].h_m1); low_rate_m1_i = RCW'(vecs[i].l_m1);
      even_50_50_en_i = vecs[i].even; diff_en_i = vecs[i].diff; enable_i = 1'b1;
      tick();
      check("first_rise", longint'(events_o), 8);
      per = vecs[i].exp_hi + vecs[i].exp_lo;
      rec_clk.delete();
      rec_clk.push_back(clk_o);
      for (int k = 1; k < 2 * per; k++) begin
        tick();
        rec_clk.push_back(clk_o);
      end
      check("high_len", run_len(0, 1'b1), vecs[i].exp_hi);
      check("low_len", run_len(vecs[i].exp_hi, 1'b0), vecs[i].exp_lo);
      check("unlocked_before_2nd_end", longint'(locked_o), 0);
      tick();
      check("locked_after_2nd_period", longint'(locked_o), 1);
    end

    // Rate change mid-HIGH: no runt, new length next period, lock drops then recovers
    do_reset();
    high_rate_m1_i = 8'd2; low_rate_m1_i = 8'd4; enable_i = 1'b1;
    for (int k = 0; k < 17; k++) tick();
    check("locked_before_change", longint'(locked_o), 1);
    tick();
    high_rate_m1_i = 8'd5;
    rec_clk.delete(); rec_lock.delete();
    for (int k = 0; k < 30; k++) begin
      tick();
      rec_clk.push_back(clk_o); rec_lock.push_back(locked_o);
    end
    check("cur_high_tail", run_len(0, 1'b1), 1);
    check("low_after_change", run_len(1, 1'b0), 5);
    check("new_high_len", run_len(6, 1'b1), 6);
    check("lock_held_old_period", longint'(rec_lock[5]), 1);
    check("lock_drop_at_relatch", longint'(rec_lock[6]), 0);
    check("lock_not_yet", longint'(rec_lock[27]), 0);
    check("lock_reasserted", longint'(rec_lock[28]), 1);

    // Pause mid-HIGH: period completes, phantom periods counted, clean restart
    do_reset();
    high_rate_m1_i = 8'd2; low_rate_m1_i = 8'd4; enable_i = 1'b1;
    tick(); tick();
    pause_req_i = 1'b1;
    n = 0;
    while (!pause_active_o && n < 20) begin tick(); n++; end
    check("pause_entry_latency", n, 7);
    for (int k = 0; k < 15; k++) tick();
    check("pause_dur_16", longint'(pause_duration_o), 1);
    tick();
    check("pause_dur_17", longint'(pause_duration_o), 2);
    check("pause_clk_low", longint'({clk_o, events_o}), 0);
    pause_req_i = 1'b0;
    tick();
    check("rise_after_release", longint'(events_o), 8);
    check("dur_held_after_exit", longint'(pause_duration_o), 2);

    // Stop mid-HIGH, then reset mid-HIGH
    do_reset();
    diff_en_i = 1'b1; high_rate_m1_i = 8'd2; low_rate_m1_i = 8'd4; enable_i = 1'b1;
    tick(); tick();
    enable_i = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("stop_last_low", longint'(events_o), 1);
    tick();
    check("stop_idle", longint'({clk_o, events_o}), 0);
    check("idle_diff_pins", longint'(pins_o), 1);
    enable_i = 1'b1;
    tick(); tick();
    sys_rst_n = 1'b0;
    tick();
    check("reset_mid_high", longint'(dut_vec()), 0);
    sys_rst_n = 1'b1;

    // Long pause saturates the narrow duration counter
    do_reset();
    enable_i = 1'b1;
    tick();
    pause_req_i = 1'b1;
    n = 0;
    while (!pause_active_o && n < 10) begin tick(); n++; end
    check("sat_pause_entered", longint'(pause_active_o), 1);
    for (int k = 0; k < 20; k++) tick();
    check("dur_saturated", longint'(pause_duration_o), 3);
    enable_i = 1'b0;
    tick();
    check("stop_from_pause", longint'(pause_active_o), 0);
    check("dur_sat_held", longint'(pause_duration_o), 3);

    // Randomised traffic against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) high_rate_m1_i = RCW'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) low_rate_m1_i = RCW'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) enable_i = ~enable_i;
      if ($urandom_range(0, 24) == 0) pause_req_i = ~pause_req_i;
      if ($urandom_range(0, 49) == 0) diff_en_i = ~diff_en_i;
      if ($urandom_range(0, 49) == 0) even_50_50_en_i = ~even_50_50_en_i;
      sys_rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
